muldiv_unit: RTL

//  Iterative MIPS HI/LO multiply/divide unit in the Execute stage (MULT, MULTU, DIV, DIVU, MTHI, MTLO).

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/muldiv_core.sv | 58 +++++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Accumulator datapath for the multiply/divide unit: one shift-add or one
// restoring-divide step per cycle on a 2*XLEN accumulator.
// Optional feature: MDU_FAST_MULT_EN loads the full product in one cycle.
module muldiv_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              load,
  input  logic              load_div,
  input  logic              step,
  input  logic              step_div,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] acc
);

  logic [XLEN-1:0] b_q;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   rsh;
  logic [XLEN:0]   diff;

  // Multiply: add multiplicand into the upper half (carry kept in bit XLEN).
  assign sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b_q};
  // Divide: partial remainder shifted left with the next dividend bit, then trial-subtracted.
  assign rsh  = acc[2*XLEN-1:XLEN-1];
  assign diff = rsh - {1'b0, b_q};

  // Load operands on issue, then advance one multiply or divide step per cycle.
  always_ff @(posedge clk) begin
    if (load) begin
      b_q <= b;
      if (load_div) begin
        acc <= {{XLEN{1'b0}}, a};
      end else begin
`ifdef MDU_FAST_MULT_EN
        acc <= {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
`else
        acc <= {{XLEN{1'b0}}, a};
`endif
      end
    end else if (step) begin
      if (step_div) begin
        if (!diff[XLEN]) begin
          acc <= {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
          acc <= {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
      end else begin
        if (acc[0]) begin
          acc <= {sum, acc[XLEN-1:1]};
        end else begin
          acc <= {1'b0, acc[2*XLEN-1:1]};
        end
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Operands are reduced to magnitudes on issue, processed by muldiv_core, and
// the recorded signs are applied in the FIX state before HI/LO are written.
// Optional feature: MDU_FAST_MULT_EN gives single-cycle multiplies (IDLE -> FIX).
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_e,
  input  mdu_op_t         op_e,
  input  logic [XLEN-1:0] srca_e,
  input  logic [XLEN-1:0] srcb_e,
  input  logic            mthi_e,
  input  logic            mtlo_e,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy_e,
  output logic            done
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  mdu_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              neg_q;
  logic              neg_r;
  logic              is_div_q;
  logic              dz_q;
  logic [XLEN-1:0]   dz_hi;

  logic              sa;
  logic              sb;
  logic              is_signed;
  logic              is_div;
  logic              div_zero;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              issue;
  logic [2*XLEN-1:0] acc;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign sa        = srca_e[XLEN-1];
  assign sb        = srcb_e[XLEN-1];
  assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign is_div    = (op_e == OP_DIV) || (op_e == OP_DIVU);
  assign div_zero  = is_div && (srcb_e == '0);
  assign a_mag     = neg_if(srca_e, is_signed && sa);
  assign b_mag     = neg_if(srcb_e, is_signed && sb);
  assign issue     = (state == S_IDLE) && start_e;

  // The hazard unit must see busy in the issue cycle itself, hence combinational.
  assign busy_e    = start_e | (state != S_IDLE);

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .load     (issue),
    .load_div (is_div),
    .step     ((state == S_MUL) || (state == S_DIV)),
    .step_div (state == S_DIV),
    .a        (a_mag),
    .b        (b_mag),
    .acc      (acc)
  );

  // Divide-by-zero keeps the raw dividend for HI.
  always_ff @(posedge clk) begin
    if (issue) dz_hi <= srca_e;
  end

  // Control FSM, iteration counter, sign fix and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_e) begin
            neg_q    <= is_signed && (sa ^ sb);
            neg_r    <= is_signed && (is_div ? sa : (sa ^ sb));
            is_div_q <= is_div;
            dz_q     <= div_zero;
            cnt      <= CNT_W'(XLEN);
            if (is_div) begin
              if (div_zero) begin
                state <= S_FIX;
                done  <= 1'b1;
              end else begin
                state <= S_DIV;
              end
            end else begin
`ifdef MDU_FAST_MULT_EN
              state <= S_FIX;
              done  <= 1'b1;
`else
              state <= S_MUL;
`endif
            end
          end else begin
            if (mthi_e) hi <= srca_e;
            if (mtlo_e) lo <= srca_e;
          end
        end
        S_MUL, S_DIV: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= S_FIX;
            done  <= 1'b1;
          end
        end
        S_FIX: begin
          if (dz_q) begin
            hi <= dz_hi;
            lo <= '1;
          end else if (is_div_q) begin
            lo <= neg_if(acc[XLEN-1:0], neg_q);
            hi <= neg_if(acc[2*XLEN-1:XLEN], neg_r);
          end else begin
            {hi, lo} <= neg_if2(acc, neg_q);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
